// File: rtl/seq_pkg.sv
// Shared definitions for the serial-bit sequence path: transmitter state
// encoding, the 1001-family default pattern and the repeat counter width.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } tx_state_t;

    localparam logic [3:0] DEFAULT_PATTERN_1001 = 4'b1001;
    localparam int         REP_W                = 4;

endpackage

// File: rtl/serial_bit_counter.sv
// Mod-WIDTH up-counter with synchronous clear, enable and terminal-count flag;
// tracks the bit position inside one pattern transmission.
module serial_bit_counter #(
    parameter int WIDTH = 4,
    parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    assign tc = (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: loads a pattern word plus repeat count and
// shifts it out MSB-first on a registered serial line, repeating without gaps.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line idle (0), load_ready high, waiting for load_valid
// ST_SHIFT | one pattern bit per clock, wraps to MSB while repeats remain
// ST_DONE  | single-cycle done pulse, loads refused, then back to idle
module serial_pattern_tx
    import seq_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter logic [WIDTH-1:0] DEFAULT_PATTERN = WIDTH'(DEFAULT_PATTERN_1001)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_pattern,
    input  logic [REP_W-1:0] load_repeat,
    input  logic             abort,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    tx_state_t        state, state_nxt;
    logic [WIDTH-1:0] pattern;
    logic [REP_W-1:0] rep_cnt;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    bit_idx_nxt;
    logic             bit_tc;
    logic             cnt_clr, cnt_en;
    logic             load_take, rep_dec, rep_clr;
    logic             out_bit_nxt, out_valid_nxt;

    serial_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (bit_cnt),
        .tc  (bit_tc)
    );

    // Index of the bit that will be on the line after this edge when the
    // counter is mid-pattern: WIDTH-1-(bit_cnt+1).
    assign bit_idx_nxt = CW'(WIDTH - 2) - bit_cnt;

    always_comb begin
        state_nxt     = state;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
        load_take     = 1'b0;
        rep_dec       = 1'b0;
        rep_clr       = 1'b0;
        out_bit_nxt   = 1'b0;
        out_valid_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_valid) begin
                    load_take     = 1'b1;
                    cnt_clr       = 1'b1;
                    state_nxt     = ST_SHIFT;
                    out_valid_nxt = 1'b1;
                    out_bit_nxt   = load_pattern[WIDTH-1];
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    cnt_clr   = 1'b1;
                    rep_clr   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (bit_tc) begin
                    if (rep_cnt != '0) begin
                        cnt_en        = 1'b1;
                        rep_dec       = 1'b1;
                        out_valid_nxt = 1'b1;
                        out_bit_nxt   = pattern[WIDTH-1];
                    end else begin
                        cnt_clr   = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end else begin
                    cnt_en        = 1'b1;
                    out_valid_nxt = 1'b1;
                    out_bit_nxt   = pattern[bit_idx_nxt];
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                cnt_clr   = 1'b1;
                rep_clr   = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pattern    <= DEFAULT_PATTERN;
            rep_cnt    <= '0;
            out_bit    <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state <= state_nxt;
            if (load_take) begin
                pattern <= load_pattern;
                rep_cnt <= load_repeat;
            end else if (rep_clr) begin
                rep_cnt <= '0;
            end else if (rep_dec) begin
                rep_cnt <= rep_cnt - 1'b1;
            end
            // Status flags are registered from the next state so they depend
            // on state only and carry no combinational input path.
            out_bit    <= out_bit_nxt;
            out_valid  <= out_valid_nxt;
            busy       <= (state_nxt != ST_IDLE);
            done       <= (state_nxt == ST_DONE);
            load_ready <= (state_nxt == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: single send, repeat wrap, abort,
// held-valid handshake spacing, abort+load in idle and asynchronous reset.
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [3:0] load_pattern = 4'b0000;
    logic [3:0] load_repeat = 4'd0;
    logic       abort = 1'b0;
    logic       out_bit;
    logic       out_valid;
    logic       busy;
    logic       done;

    int n_chk = 0;
    int n_bad = 0;

    serial_pattern_tx #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_pattern (load_pattern),
        .load_repeat  (load_repeat),
        .abort        (abort),
        .out_bit      (out_bit),
        .out_valid    (out_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue a load from idle; inputs are scrambled right after acceptance.
    task automatic load(input logic [3:0] p, input logic [3:0] r);
        @(negedge clk);
        load_valid   = 1'b1;
        load_pattern = p;
        load_repeat  = r;
        @(posedge clk);
        #1;
        load_valid   = 1'b0;
        load_pattern = ~p;
        load_repeat  = 4'd0;
    endtask

    initial begin
        logic [11:0] exp_stream;
        logic [3:0]  win;
        logic [3:0]  exp4;
        logic [5:0]  exp6;
        int          n_det;
        int          acc[$];

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_out_bit", 32'(out_bit), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_load_ready", 32'(load_ready), 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // single send
        load(4'b1001, 4'd0);
        exp4 = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("single_valid", 32'(out_valid), 1);
            chk("single_bit", 32'(out_bit), 32'(exp4[3-i]));
            chk("single_ready", 32'(load_ready), 0);
        end
        @(negedge clk);
        chk("single_done", 32'(done), 1);
        chk("single_done_valid", 32'(out_valid), 0);
        chk("single_done_ready", 32'(load_ready), 0);
        chk("single_done_busy", 32'(busy), 1);
        @(negedge clk);
        chk("single_after_done", 32'(done), 0);
        chk("single_after_ready", 32'(load_ready), 1);
        chk("single_after_busy", 32'(busy), 0);

        // repeat / wrap with an overlapping 1001 detector model
        load(4'b1001, 4'd2);
        exp_stream = 12'b1001_1001_1001;
        win = 4'b0000;
        n_det = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("rep_valid", 32'(out_valid), 1);
            chk("rep_bit", 32'(out_bit), 32'(exp_stream[11-i]));
            chk("rep_done_low", 32'(done), 0);
            if (out_valid) begin
                win = {win[2:0], out_bit};
                if (win == 4'b1001) n_det++;
            end
        end
        chk("rep_detect_count", 32'(n_det), 3);
        @(negedge clk);
        chk("rep_done", 32'(done), 1);
        chk("rep_done_valid", 32'(out_valid), 0);
        @(negedge clk);
        chk("rep_after_done", 32'(done), 0);
        chk("rep_after_ready", 32'(load_ready), 1);

        // abort on the 6th valid cycle
        load(4'b1011, 4'd3);
        exp6 = 6'b101110;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_valid", 32'(out_valid), 1);
            chk("abort_bit", 32'(out_bit), 32'(exp6[5-i]));
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_valid_off", 32'(out_valid), 0);
        chk("abort_ready", 32'(load_ready), 1);
        chk("abort_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 0);
            chk("abort_idle_valid", 32'(out_valid), 0);
        end

        // held load_valid with changing pattern, repeat 1
        exp4 = 4'b0110;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 8) begin
                chk("hs_valid", 32'(out_valid), 1);
                chk("hs_bit", 32'(out_bit), 32'(exp4[3 - ((c - 1) % 4)]));
            end
            if (load_ready) acc.push_back(c);
            load_valid   = 1'b1;
            load_pattern = (c == 0) ? 4'b0110 : 4'(c + 7);
            load_repeat  = 4'd1;
        end
        @(negedge clk);
        load_valid = 1'b0;
        chk("hs_accept_count", 32'(acc.size()), 2);
        if (acc.size() >= 2) begin
            chk("hs_first_accept", 32'(acc[0]), 0);
            chk("hs_spacing", 32'(acc[1] - acc[0]), 10);
        end
        repeat (12) @(negedge clk);
        chk("hs_back_idle", 32'(load_ready), 1);

        // abort together with load in idle
        @(negedge clk);
        abort        = 1'b1;
        load_valid   = 1'b1;
        load_pattern = 4'b1100;
        load_repeat  = 4'd0;
        @(posedge clk);
        #1;
        abort      = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        chk("edge_valid", 32'(out_valid), 1);
        chk("edge_msb", 32'(out_bit), 1);
        @(negedge clk);
        chk("edge_bit1", 32'(out_bit), 1);
        repeat (5) @(negedge clk);
        chk("edge_idle", 32'(load_ready), 1);

        // asynchronous reset mid-transmission
        load(4'b1111, 4'd3);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_bit", 32'(out_bit), 0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_ready", 32'(load_ready), 1);
        repeat (2) @(negedge clk);
        chk("arst_hold_valid", 32'(out_valid), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_release_done", 32'(done), 0);
        load(4'b1010, 4'd0);
        @(negedge clk);
        chk("post_rst_bit0", 32'(out_bit), 1);
        @(negedge clk);
        chk("post_rst_bit1", 32'(out_bit), 0);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
